// File: rtl/chip8_vga_pkg.sv
// chip8_vga_pkg: raster constants, pixel scaling and display indexing shared by the CHIP-8 VGA generator and capture.
package chip8_vga_pkg;
  localparam int H_SYNC = 4;
  localparam int H_BP = 22;
  localparam int H_VIS = 128;
  localparam int H_FP = 11;
  localparam int H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
  localparam int V_SYNC = 5;
  localparam int V_BP = 60;
  localparam int V_VIS = 640;
  localparam int V_FP = 45;
  localparam int V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;
  localparam int X_SCALE = 2;
  localparam int Y_SCALE = 20;
  localparam int DISP_W = 64;
  localparam int DISP_H = 32;
  typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} cap_state_e;
  // Row-major with x mirrored so pixel (0,y) lands in the MSB of its row.
  function automatic logic [10:0] disp_idx(input logic [4:0] y, input logic [5:0] x);
    return {y, ~x};
  endfunction
endpackage

// File: rtl/vga_sync_tracker.sv
// vga_sync_tracker: registers the VGA inputs, detects sync edges, tracks line/frame indices and flags timing violations.
module vga_sync_tracker
  import chip8_vga_pkg::*;
#(
  parameter int LINE_PX = H_TOTAL,
  parameter int FRAME_LN = V_TOTAL
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       color_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       locked_i,
  output logic       color_o,
  output logic       hfall_o,
  output logic       vfall_o,
  output logic [7:0] s_o,
  output logic [9:0] l_o,
  output logic       h_err_o,
  output logic       v_err_o,
  output logic       w_err_o
);
  logic       c_q, h_q, v_q, hp_q, vp_q;
  logic [7:0] s_q, s_d;
  logic [9:0] l_q, l_d;
  logic [2:0] w_q, w_d;
  assign hfall_o = hp_q & ~h_q;
  assign vfall_o = vp_q & ~v_q;
  assign color_o = c_q;
  assign s_o = s_d;
  assign l_o = l_d;
  // Checks compare against the index of the sample before the edge.
  assign h_err_o = hfall_o && s_q != 8'(LINE_PX - 1);
  assign v_err_o = vfall_o && l_q != 10'(FRAME_LN - 1);
  assign w_err_o = ~hp_q && h_q && w_q != 3'(H_SYNC);
  always_comb begin
    s_d = hfall_o ? 8'd0 : (s_q == 8'hff && !locked_i) ? s_q : s_q + 8'd1;
    l_d = hfall_o ? (vfall_o ? 10'd0 : l_q + 10'd1) : l_q;
    w_d = hfall_o ? 3'd1 : (!h_q && w_q != 3'd7) ? w_q + 3'd1 : w_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_q <= 1'b0;
      h_q <= 1'b1;
      v_q <= 1'b1;
      hp_q <= 1'b1;
      vp_q <= 1'b1;
      s_q <= '0;
      l_q <= '0;
      w_q <= '0;
    end else begin
      c_q <= color_i;
      h_q <= hsync_i;
      v_q <= vsync_i;
      hp_q <= h_q;
      vp_q <= v_q;
      s_q <= s_d;
      l_q <= l_d;
      w_q <= w_d;
    end
  end
endmodule

// File: rtl/vga_capture.sv
// vga_capture: locks to the CHIP-8 VGA raster and publishes each cleanly captured 64x32 frame.
module vga_capture
  import chip8_vga_pkg::*;
#(
  parameter int LINE_PX = H_TOTAL,
  parameter int FRAME_LN = V_TOTAL,
  parameter int SAMPLE_PX0 = H_SYNC + H_BP + X_SCALE,
  parameter int SAMPLE_LN0 = V_SYNC + V_BP + Y_SCALE / 2,
  parameter int ROW_LN = Y_SCALE
) (
  input  logic          pixel_clk_7_425mhz,
  input  logic          rst,
  input  logic          color,
  input  logic          hsync,
  input  logic          vsync,
  output logic [2047:0] display,
  output logic          frame_valid,
  output logic          locked,
  output logic          sync_error
);
  logic          c_s, hfall, vfall, h_err, v_err, w_err;
  logic [7:0]    s_cur, px_off;
  logic [9:0]    l_cur, ln_off;
  logic          active, line_err, publish, hit;
  logic          dirty_q, dirty_d;
  logic [5:0]    cap_x;
  logic [4:0]    cap_y;
  logic [2047:0] shadow_q;
  cap_state_e    state_q, state_d;
  vga_sync_tracker #(.LINE_PX(LINE_PX), .FRAME_LN(FRAME_LN)) u_trk (
    .clk_i(pixel_clk_7_425mhz), .rst_i(rst), .color_i(color), .hsync_i(hsync), .vsync_i(vsync),
    .locked_i(locked), .color_o(c_s), .hfall_o(hfall), .vfall_o(vfall), .s_o(s_cur), .l_o(l_cur),
    .h_err_o(h_err), .v_err_o(v_err), .w_err_o(w_err)
  );
  assign active = state_q != ST_UNLOCKED;
  assign line_err = active && (h_err || w_err);
  assign px_off = s_cur - 8'(SAMPLE_PX0);
  assign ln_off = l_cur - 10'(SAMPLE_LN0);
  assign cap_x = 6'(px_off / 8'(X_SCALE));
  assign cap_y = 5'(ln_off / 10'(ROW_LN));
  assign hit = s_cur >= 8'(SAMPLE_PX0) && px_off < 8'(X_SCALE * DISP_W) && px_off % 8'(X_SCALE) == 8'd0
            && l_cur >= 10'(SAMPLE_LN0) && ln_off < 10'(ROW_LN * DISP_H) && ln_off % 10'(ROW_LN) == 10'd0;
  // A line-level error outranks a coincident vsync fall.
  always_comb begin
    state_d = state_q;
    dirty_d = dirty_q;
    publish = 1'b0;
    if (!active) begin
      state_d = vfall ? ST_ACQUIRE : ST_UNLOCKED;
      dirty_d = 1'b0;
    end else if (line_err) begin
      state_d = ST_UNLOCKED;
      dirty_d = 1'b1;
    end else if (vfall) begin
      state_d = (v_err || dirty_q) ? ST_ACQUIRE : ST_LOCKED;
      publish = state_q == ST_LOCKED && !v_err && !dirty_q;
      dirty_d = 1'b0;
    end
  end
  always_ff @(posedge pixel_clk_7_425mhz or posedge rst) begin
    if (rst) begin
      state_q <= ST_UNLOCKED;
      dirty_q <= 1'b0;
      shadow_q <= '0;
      display <= '0;
      frame_valid <= 1'b0;
      locked <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
      if (hit) shadow_q[disp_idx(cap_y, cap_x)] <= c_s;
      if (publish) display <= shadow_q;
      frame_valid <= publish;
      locked <= state_d == ST_LOCKED;
      sync_error <= active && (h_err || v_err || w_err);
    end
  end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives a compact raster frame by frame and checks publish, lock and error behaviour against a frame-level model.
module tb_vga_capture;
  localparam int LP = 134;
  localparam int FL = 34;
  localparam int PX0 = 6;
  localparam int LN0 = 2;
  typedef struct {
    int pat;
    int nlines;
    int long_ln;
    int rst_ln;
    int fv;
    int serr;
    int lock;
  } frame_t;
  logic clk = 1'b0, rst = 1'b1, color = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [2047:0] display;
  logic frame_valid, locked, sync_error;
  int checks = 0, failures = 0, fv_cnt = 0, se_cnt = 0, prev_kind = -1;
  logic [2047:0] disp_fv = '0, cur_pat = '0, prev_pat = '0, exp_disp = '0;
  frame_t tbl[13];

  vga_capture #(.LINE_PX(LP), .FRAME_LN(FL), .SAMPLE_PX0(PX0), .SAMPLE_LN0(LN0), .ROW_LN(1)) dut (
    .pixel_clk_7_425mhz(clk), .rst(rst), .color(color), .hsync(hsync), .vsync(vsync),
    .display(display), .frame_valid(frame_valid), .locked(locked), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_disp(input string name, input logic [2047:0] act, input logic [2047:0] exp);
    int bad = 0;
    checks++;
    if (act !== exp) begin
      failures++;
      for (int i = 2047; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
      $display("FAIL %s: display bit %0d is %b expected %b (%0d ones vs %0d)", name, bad, act[bad], exp[bad],
               $countones(act), $countones(exp));
    end
  endtask

  // One raster sample: observe outputs at the falling edge, then present the next inputs.
  task automatic step(input logic h, input logic v, input logic c);
    @(negedge clk);
    if (frame_valid === 1'b1) begin
      fv_cnt++;
      disp_fv = display;
    end
    if (sync_error === 1'b1) se_cnt++;
    hsync = h;
    vsync = v;
    color = c;
  endtask

  // Pattern bits only at the exact capture points; noise everywhere else.
  function automatic logic pix(input int s, input int l);
    if (s >= PX0 && s < PX0 + 128 && (s - PX0) % 2 == 0 && l >= LN0 && l < LN0 + 32)
      return cur_pat[(l - LN0) * 64 + 63 - (s - PX0) / 2];
    return 1'($urandom);
  endfunction

  task automatic send_frame(input frame_t f, input int idx);
    for (int l = 0; l < f.nlines; l++) begin
      for (int s = 0; s < ((l == f.long_ln) ? LP + 1 : LP); s++) begin
        step(s >= 4, l >= 2, pix(s, l));
        if (l == f.rst_ln && s == 0) begin
          chk($sformatf("frame%0d locked before rst", idx), locked, 1);
          rst = 1'b1;
          #1;
          chk_disp($sformatf("frame%0d display in rst", idx), display, '0);
          chk($sformatf("frame%0d frame_valid in rst", idx), frame_valid, 0);
          chk($sformatf("frame%0d locked in rst", idx), locked, 0);
          chk($sformatf("frame%0d sync_error in rst", idx), sync_error, 0);
        end
        if (l == f.rst_ln && s == 3) rst = 1'b0;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{0, FL, -1, -1, 0, 0, 0};
    tbl[1]  = '{0, FL, -1, -1, 0, 0, 1};
    tbl[2]  = '{1, FL, -1, -1, 1, 0, 1};
    tbl[3]  = '{2, FL, 10, -1, 1, 1, 0};
    tbl[4]  = '{2, FL, -1, -1, 0, 0, 0};
    tbl[5]  = '{2, FL, -1, -1, 0, 0, 1};
    tbl[6]  = '{2, FL - 1, -1, -1, 1, 0, 1};
    tbl[7]  = '{2, FL, -1, -1, 0, 1, 0};
    tbl[8]  = '{2, FL, -1, -1, 0, 0, 1};
    tbl[9]  = '{2, FL, -1, 15, 1, 0, 0};
    tbl[10] = '{2, FL, -1, -1, 0, 0, 0};
    tbl[11] = '{2, FL, -1, -1, 0, 0, 1};
    tbl[12] = '{2, FL, -1, -1, 1, 0, 1};
    repeat (3) @(negedge clk);
    chk_disp("reset display", display, '0);
    chk("reset frame_valid", frame_valid, 0);
    chk("reset locked", locked, 0);
    chk("reset sync_error", sync_error, 0);
    rst = 1'b0;
    repeat (6) step(1'b1, 1'b1, 1'b0);
    chk("idle sync_error pulses", se_cnt, 0);
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].pat == 0) for (int b = 0; b < 2048; b++) cur_pat[b] = 1'(b) ^ 1'(b >> 6);
      else if (tbl[i].pat == 1) begin
        cur_pat = '0;
        cur_pat[63] = 1'b1;
        cur_pat[1984] = 1'b1;
      end else for (int w = 0; w < 64; w++) cur_pat[w * 32 +: 32] = $urandom;
      fv_cnt = 0;
      se_cnt = 0;
      send_frame(tbl[i], i);
      chk($sformatf("frame%0d frame_valid pulses", i), fv_cnt, tbl[i].fv);
      chk($sformatf("frame%0d sync_error pulses", i), se_cnt, tbl[i].serr);
      chk($sformatf("frame%0d locked at end", i), locked, tbl[i].lock);
      if (tbl[i].fv != 0) begin
        chk_disp($sformatf("frame%0d published display", i), disp_fv, prev_pat);
        exp_disp = prev_pat;
        if (prev_kind == 1) begin
          chk("single pixel ones", $countones(disp_fv), 2);
          chk("single pixel bit63", disp_fv[63], 1);
          chk("single pixel bit1984", disp_fv[1984], 1);
        end
      end
      if (tbl[i].rst_ln >= 0) exp_disp = '0;
      chk_disp($sformatf("frame%0d held display", i), display, exp_disp);
      prev_pat = cur_pat;
      prev_kind = tbl[i].pat;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
